// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide sequencer owning HI/LO
//
// Purpose:
//   Runs MULT/MULTU/DIV/DIVU for the EX stage. It uses a 32-step shift-add
//   multiplier and a restoring divider on operand magnitudes. The sign fix-up
//   happens in a final FIX cycle, and the result is written into the
//   architectural HI/LO registers at that point.
//
// Build option:
//   MULDIV_DIV_EN - when defined, the divider datapath is compiled in. When
//                   undefined, DIV/DIVU complete immediately with HI/LO
//                   untouched.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     EX issues a mul/div this cycle
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      rs / rt operands
//   hilo_acc  ID holds mfhi/mflo/mthi/mtlo
//   we_hi     mthi write strobe
//   we_lo     mtlo write strobe
//   wdata     mthi/mtlo data
//   busy      operation in progress (CALC or FIX)
//   done      one-cycle completion pulse
//   stall     busy & (start | hilo_acc)
//   hi, lo    architectural HI/LO
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_acc,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    // Multiplicand for multiply, divisor for divide.
    logic [31:0] opnd_q, opnd_d;
    // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        is_signed;
    logic [31:0] abs_a, abs_b;
    logic [32:0] msum;
    logic [63:0] mul_next;
    logic [63:0] prod;

`ifdef MULDIV_DIV_EN
    logic        is_div_q, is_div_d;
    logic        div0_q, div0_d;
    logic [32:0] dshift;
    logic [33:0] dtrial;
    logic [63:0] div_next;
    logic [31:0] quot_fix, rem_fix;
`endif

    // A new operation may start from IDLE or from the DONE cycle.
    assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign is_signed = ~op[0];
    assign abs_a     = (is_signed && a[31]) ? -a : a;
    assign abs_b     = (is_signed && b[31]) ? -b : b;

    // Shift-add step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right, carry included.
    assign msum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {msum, acc_q[31:1]};
    assign prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    // Restoring step. The shifted remainder can need 33 bits, so the trial
    // subtract is done in 34 bits and its top bit is the borrow.
    assign dshift   = {acc_q[63:32], acc_q[31]};
    assign dtrial   = {1'b0, dshift} - {2'b00, opnd_q};
    assign div_next = dtrial[33] ? {dshift[31:0], acc_q[30:0], 1'b0}
                                 : {dtrial[31:0], acc_q[30:0], 1'b1};
    assign quot_fix = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = sa_q ? -acc_q[63:32] : acc_q[63:32];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
`ifdef MULDIV_DIV_EN
                    state_d = S_CALC;
`else
                    state_d = op[1] ? S_DONE : S_CALC;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC:  state_d = (count_q == 5'd0) ? S_FIX : S_CALC;
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy  = (state_q == S_CALC) || (state_q == S_FIX);
        done  = (state_q == S_DONE);
        stall = busy & (start | hilo_acc);
    end

    assign hi = hi_q;
    assign lo = lo_q;

    // Datapath next-state
    always_comb begin
        count_d = count_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
        div0_d   = div0_q;
`endif

        // mthi/mtlo land only when not busy. A result loaded in FIX
        // overwrites a write that coincided with start.
        if (state_q == S_IDLE || state_q == S_DONE) begin
            if (we_hi) hi_d = wdata;
            if (we_lo) lo_d = wdata;
        end

        if (accept) begin
            count_d = 5'd31;
            sa_d    = is_signed & a[31];
            sb_d    = is_signed & b[31];
            if (op[1]) begin
                opnd_d = abs_b;
                acc_d  = {32'd0, abs_a};
            end else begin
                opnd_d = abs_a;
                acc_d  = {32'd0, abs_b};
            end
`ifdef MULDIV_DIV_EN
            is_div_d = op[1];
            div0_d   = (b == 32'd0);
`endif
        end

        if (state_q == S_CALC) begin
`ifdef MULDIV_DIV_EN
            acc_d = is_div_q ? div_next : mul_next;
`else
            acc_d = mul_next;
`endif
            if (count_q != 5'd0) count_d = count_q - 5'd1;
        end

        if (state_q == S_FIX) begin
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
                // Divide by zero leaves remainder = a naturally; only the
                // quotient needs forcing to all ones.
                hi_d = rem_fix;
                lo_d = div0_q ? 32'hFFFF_FFFF : quot_fix;
            end else begin
                hi_d = prod[63:32];
                lo_d = prod[31:0];
            end
`else
            hi_d = prod[63:32];
            lo_d = prod[31:0];
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 5'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opnd_q  <= 32'd0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hilo_acc;
    logic        we_hi, we_lo;
    logic [31:0] wdata;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [31:0] model_hi, model_lo;

    muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hilo_acc (hilo_acc),
        .we_hi    (we_hi),
        .we_lo    (we_lo),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mul_ref(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe, ye;
        xe = o[0] ? {32'd0, x} : {{32{x[31]}}, x};
        ye = o[0] ? {32'd0, y} : {{32{y[31]}}, y};
        return xe * ye;
    endfunction

    // Issues one operation and follows it to its done pulse. With disturb
    // set, mid-flight it raises hilo_acc, tries mthi/mtlo and a second start.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp,
                          input int exp_lat, input int exp_busy, input bit disturb);
        int n;
        int bcnt;
        logic [63:0] want;
        sb_q.push_back(exp);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        n     = 1;
        bcnt  = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) bcnt++;
            if (disturb && n == 5) begin
                hilo_acc = 1'b1;
                we_hi    = 1'b1;
                we_lo    = 1'b1;
                wdata    = 32'hDEAD_BEEF;
                start    = 1'b1;
                op       = 2'b01;
                #1;
                chk({tag, "_stall_busy"}, {63'd0, stall}, 64'd1);
            end
            if (disturb && n == 6) begin
                chk({tag, "_lo_write_ignored"}, {32'd0, lo}, {32'd0, model_lo});
                chk({tag, "_hi_write_ignored"}, {32'd0, hi}, {32'd0, model_hi});
                we_hi = 1'b0;
                we_lo = 1'b0;
                start = 1'b0;
            end
            if (disturb && n == 33) begin
                chk({tag, "_stall_fix"}, {63'd0, stall}, 64'd1);
            end
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
        if (sb_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
            want = 64'd0;
        end else begin
            want = sb_q.pop_front();
            chk({tag, "_hilo"}, {hi, lo}, want);
        end
        if (disturb) chk({tag, "_stall_done"}, {63'd0, stall}, 64'd0);
        hilo_acc = 1'b0;
        model_hi = want[63:32];
        model_lo = want[31:0];
        step();
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        hilo_acc = 1'b0; we_hi = 1'b0; we_lo = 1'b0; wdata = 32'd0;
        model_hi = 32'd0; model_lo = 32'd0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy",  {63'd0, busy},  64'd0);
        chk("rst_done",  {63'd0, done},  64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_hilo",  {hi, lo},       64'd0);

        // mtlo / mthi in IDLE
        we_lo = 1'b1; wdata = 32'd5;
        step();
        we_lo = 1'b0;
        chk("mtlo_idle", {hi, lo}, {32'd0, 32'd5});
        we_hi = 1'b1; wdata = 32'h1234_5678;
        step();
        we_hi = 1'b0;
        chk("mthi_idle", {hi, lo}, {32'h1234_5678, 32'd5});
        model_hi = 32'h1234_5678; model_lo = 32'd5;

        run_op("multu_ff_x2", 2'b01, 32'hFFFF_FFFF, 32'h2, {32'h1, 32'hFFFF_FFFE}, 34, 33, 1'b0);
        run_op("mult_m3_x7",  2'b00, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 34, 33, 1'b0);
        run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0}, 34, 33, 1'b0);
        run_op("multu_ff_sq", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h1}, 34, 33, 1'b0);
        run_op("mult_stall",  2'b00, 32'd1000, 32'hFFFF_FFFF, {32'hFFFF_FFFF, 32'hFFFF_FC18}, 34, 33, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ro = 2'($urandom_range(0, 1));
            rx = $urandom;
            ry = $urandom;
            run_op("mul_rand", ro, rx, ry, mul_ref(ro, rx, ry), 34, 33, 1'b0);
        end

`ifdef MULDIV_DIV_EN
        run_op("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 33, 1'b0);
        run_op("div_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 34, 33, 1'b0);
        run_op("divu_100_0",  2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 34, 33, 1'b0);
        run_op("div_m5_0",    2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 34, 33, 1'b0);
        run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34, 33, 1'b0);
        run_op("divu_big",    2'b11, 32'hFFFF_FFFF, 32'd10, {32'd5, 32'h1999_9999}, 34, 33, 1'b0);
`else
        run_op("div_off",     2'b10, 32'hFFFF_FFF9, 32'd2, {model_hi, model_lo}, 1, 0, 1'b0);
        run_op("divu_off",    2'b11, 32'd100, 32'd0, {model_hi, model_lo}, 1, 0, 1'b0);
`endif

        // Reset in the middle of CALC (count 15), then a fresh multiply.
        start = 1'b1; op = 2'b01; a = 32'h1234; b = 32'h5678;
        step();
        start = 1'b0;
        for (int i = 1; i < 17; i++) step();
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        model_hi = 32'd0; model_lo = 32'd0;
        run_op("multu_3x4", 2'b01, 32'd3, 32'd4, {32'd0, 32'd12}, 34, 33, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
